// File: rtl/tw_factor_loader.sv
// Run-time twiddle writer: streams psi_1..psi_7 into a shadow bank, then commits all seven at once.
// Optional range check against Q is enabled by defining TW_RANGE_CHECK_EN. Start to done is at least 9 cycles.
module tw_factor_loader #(
    parameter int          DATA_WIDTH = 64,
    parameter int          NUM_TW     = 7,
    parameter logic [63:0] Q          = 64'hFFFF_FFFF_0000_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  tw_valid,
    output logic [DATA_WIDTH-1:0] psi_1,
    output logic [DATA_WIDTH-1:0] psi_2,
    output logic [DATA_WIDTH-1:0] psi_3,
    output logic [DATA_WIDTH-1:0] psi_4,
    output logic [DATA_WIDTH-1:0] psi_5,
    output logic [DATA_WIDTH-1:0] psi_6,
    output logic [DATA_WIDTH-1:0] psi_7
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            cnt;
    logic [DATA_WIDTH-1:0] shadow [NUM_TW];
    logic [DATA_WIDTH-1:0] psi_q  [NUM_TW];
    logic                  last_word;
    logic                  range_bad;
    logic                  word_ok;

    assign last_word = (cnt == 3'(NUM_TW - 1));

`ifdef TW_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] QW = DATA_WIDTH'(Q);
    assign range_bad = (s_data >= QW);
`else
    assign range_bad = 1'b0;
`endif

    // A word is stored only when it is handshaken and passes the range check.
    assign word_ok = (state == LOAD) && s_valid && !range_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // s_ready and busy depend on the state register only.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (range_bad)      state_nxt = IDLE;
                    else if (last_word) state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (word_ok) shadow[cnt] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 3'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            tw_valid <= 1'b0;
            for (int i = 0; i < NUM_TW; i++) psi_q[i] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) cnt <= 3'd0;
                end
                LOAD: begin
                    if (s_valid) begin
                        if (range_bad) err <= 1'b1;
                        else           cnt <= cnt + 3'd1;
                    end
                end
                COMMIT: begin
                    psi_q    <= shadow;
                    done     <= 1'b1;
                    tw_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign psi_1 = psi_q[0];
    assign psi_2 = psi_q[1];
    assign psi_3 = psi_q[2];
    assign psi_4 = psi_q[3];
    assign psi_5 = psi_q[4];
    assign psi_6 = psi_q[5];
    assign psi_7 = psi_q[6];

endmodule
